// File: rtl/ts_failover_selector.sv
// Four-input MPEG-2 TS failover selector.
// Each input has its own sync tracker; the locked stream with the lowest index is forwarded and streams change only on packet boundaries.
module ts_failover_selector #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h47,
    parameter int                    LOCK_CNT   = 3,
    parameter int                    UNLOCK_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            valid,
    input  logic [DATA_WIDTH-1:0] byte_data1,
    input  logic [DATA_WIDTH-1:0] byte_data2,
    input  logic [DATA_WIDTH-1:0] byte_data3,
    input  logic [DATA_WIDTH-1:0] byte_data4,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic [1:0]            sel,
    output logic [3:0]            locked,
    output logic                  switch_evt
);

    localparam int NCH = 4;
    localparam int PW  = $clog2(PKT_LEN);
    localparam int GW  = $clog2(LOCK_CNT + 1);
    localparam int MW  = $clog2(UNLOCK_CNT + 1);
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_LEN - 1);

    typedef enum logic [1:0] {T_HUNT, T_VERIFY, T_LOCK} trk_t;
    typedef enum logic {O_IDLE, O_FWD} out_t;

    logic [DATA_WIDTH-1:0] din [NCH];
    assign din[0] = byte_data1;
    assign din[1] = byte_data2;
    assign din[2] = byte_data3;
    assign din[3] = byte_data4;

    trk_t            trk_q  [NCH];
    logic [PW-1:0]   pos_q  [NCH];
    logic [GW-1:0]   good_q [NCH];
    logic [MW-1:0]   miss_q [NCH];
    logic [NCH-1:0]  locked_q;

    logic [NCH-1:0]  sync_hit;
    logic [NCH-1:0]  at_sop;
    logic [PW-1:0]   pos_nxt [NCH];

    always_comb begin
        sync_hit = '0;
        at_sop   = '0;
        for (int i = 0; i < NCH; i++) begin
            sync_hit[i] = (din[i] == SYNC_BYTE);
            at_sop[i]   = valid[i] && (pos_q[i] == '0) && sync_hit[i];
            pos_nxt[i]  = (pos_q[i] == PKT_LAST) ? '0 : pos_q[i] + 1'b1;
        end
    end

    // Only the byte at pos 0 is ever judged once the tracker has left HUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                trk_q[i]  <= T_HUNT;
                pos_q[i]  <= '0;
                good_q[i] <= '0;
                miss_q[i] <= '0;
            end
            locked_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (valid[i]) begin
                    case (trk_q[i])
                        T_HUNT: begin
                            if (sync_hit[i]) begin
                                trk_q[i]  <= T_VERIFY;
                                good_q[i] <= GW'(1);
                                pos_q[i]  <= PW'(1);
                            end
                        end
                        T_VERIFY: begin
                            pos_q[i] <= pos_nxt[i];
                            if (pos_q[i] == '0) begin
                                if (sync_hit[i]) begin
                                    good_q[i] <= good_q[i] + 1'b1;
                                    if (good_q[i] == GW'(LOCK_CNT - 1)) begin
                                        trk_q[i]    <= T_LOCK;
                                        miss_q[i]   <= '0;
                                        locked_q[i] <= 1'b1;
                                    end
                                end else begin
                                    trk_q[i]  <= T_HUNT;
                                    pos_q[i]  <= '0;
                                    good_q[i] <= '0;
                                end
                            end
                        end
                        T_LOCK: begin
                            pos_q[i] <= pos_nxt[i];
                            if (pos_q[i] == '0) begin
                                if (sync_hit[i]) begin
                                    miss_q[i] <= '0;
                                end else if (miss_q[i] == MW'(UNLOCK_CNT - 1)) begin
                                    trk_q[i]    <= T_HUNT;
                                    pos_q[i]    <= '0;
                                    good_q[i]   <= '0;
                                    miss_q[i]   <= '0;
                                    locked_q[i] <= 1'b0;
                                end else begin
                                    miss_q[i] <= miss_q[i] + 1'b1;
                                end
                            end
                        end
                        default: begin
                            trk_q[i] <= T_HUNT;
                            pos_q[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    logic       tgt_vld;
    logic [1:0] tgt;

    always_comb begin
        tgt_vld = 1'b0;
        tgt     = 2'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (locked_q[i]) begin
                tgt_vld = 1'b1;
                tgt     = 2'(i);
            end
        end
    end

    out_t                  ost_q;
    logic [1:0]            sel_q;
    logic                  ov_q;
    logic                  sop_q;
    logic                  sw_q;
    logic [DATA_WIDTH-1:0] od_q;

    // A lost lock on sel aborts at once; a better target waits for the end of the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost_q <= O_IDLE;
            sel_q <= 2'd0;
            ov_q  <= 1'b0;
            sop_q <= 1'b0;
            sw_q  <= 1'b0;
            od_q  <= '0;
        end else begin
            ov_q  <= 1'b0;
            sop_q <= 1'b0;
            sw_q  <= 1'b0;
            case (ost_q)
                O_IDLE: begin
                    if (tgt_vld && at_sop[tgt]) begin
                        ost_q <= O_FWD;
                        sel_q <= tgt;
                        ov_q  <= 1'b1;
                        sop_q <= 1'b1;
                        od_q  <= din[tgt];
                        sw_q  <= (tgt != sel_q);
                    end
                end
                O_FWD: begin
                    if (!locked_q[sel_q]) begin
                        ost_q <= O_IDLE;
                    end else if (valid[sel_q]) begin
                        ov_q  <= 1'b1;
                        od_q  <= din[sel_q];
                        sop_q <= (pos_q[sel_q] == '0);
                        if (tgt != sel_q && pos_q[sel_q] == PKT_LAST) begin
                            ost_q <= O_IDLE;
                        end
                    end
                end
                default: ost_q <= O_IDLE;
            endcase
        end
    end

    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_sop    = sop_q;
    assign sel        = sel_q;
    assign locked     = locked_q;
    assign switch_evt = sw_q;

endmodule
